rr_arbiter8: RTL and testbench

RR_ARBITER8 -- requirements
Module: rr_arbiter8

---
 rtl/rr_arbiter8.sv | 118 +++++++++++
 tb/tb_rr_arbiter8.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way fixed-priority / round-robin arbiter with hold timeout
module rr_arbiter8 #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       mode,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] a,
    output logic       v,
    output logic       to
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    logic [0:0] state;
    logic [2:0] ptr;
    logic [7:0] cnt;

    logic [2:0] fp_idx;
    logic [2:0] rr_idx;
    logic [2:0] sel_idx;
    logic [2:0] probe;
    logic       rr_found;
    logic       any_req;
    logic       rel_normal;
    logic       rel_timeout;

    // Fixed priority: later (higher) indices overwrite earlier ones.
    always_comb begin
        fp_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) begin
                fp_idx = 3'(i);
            end
        end
    end

    // Round-robin: first asserted request at or above ptr, wrapping 7 -> 0.
    always_comb begin
        rr_idx   = 3'd0;
        rr_found = 1'b0;
        probe    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            probe = ptr + 3'(i);
            if (!rr_found && req[probe]) begin
                rr_found = 1'b1;
                rr_idx   = probe;
            end
        end
    end

    always_comb begin
        any_req     = |req;
        sel_idx     = mode ? rr_idx : fp_idx;
        rel_normal  = done || !req[a] || !en;
        // A cooperative release in the limit cycle wins over the timeout.
        rel_timeout = !rel_normal && (cnt == HOLD_LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 3'd0;
            cnt   <= 8'd0;
            gnt   <= 8'd0;
            a     <= 3'd0;
            v     <= 1'b0;
            to    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    to <= 1'b0;
                    if (en && any_req) begin
                        state <= GRANT;
                        gnt   <= 8'd1 << sel_idx;
                        a     <= sel_idx;
                        v     <= 1'b1;
                        cnt   <= 8'd1;
                    end else begin
                        gnt <= 8'd0;
                        a   <= 3'd0;
                        v   <= 1'b0;
                        cnt <= 8'd0;
                    end
                end
                GRANT: begin
                    if (rel_normal || rel_timeout) begin
                        state <= IDLE;
                        gnt   <= 8'd0;
                        a     <= 3'd0;
                        v     <= 1'b0;
                        cnt   <= 8'd0;
                        ptr   <= a + 3'd1;
                        to    <= rel_timeout;
                    end else begin
                        cnt <= cnt + 8'd1;
                        to  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 8'd0;
                    a     <= 3'd0;
                    v     <= 1'b0;
                    cnt   <= 8'd0;
                    to    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed-vector bench for rr_arbiter8
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] a;
    logic       v;
    logic       to;

    int n_tests = 0;
    int n_fail  = 0;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .mode (mode),
        .req  (req),
        .done (done),
        .gnt  (gnt),
        .a    (a),
        .v    (v),
        .to   (to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input logic [2:0] idx);
        check({tag, "_v"}, 32'(v), 32'd1);
        check({tag, "_a"}, 32'(a), 32'(idx));
        check({tag, "_gnt"}, 32'(gnt), 32'(8'd1 << idx));
        check({tag, "_to"}, 32'(to), 32'd0);
    endtask

    task automatic expect_idle(input string tag, input logic exp_to);
        check({tag, "_v"}, 32'(v), 32'd0);
        check({tag, "_a"}, 32'(a), 32'd0);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_to"}, 32'(to), 32'(exp_to));
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 1'b0;
        req   = 8'd0;
        done  = 1'b0;
        tick();
        tick();
        expect_idle("reset", 1'b0);
        rst_n = 1'b1;

        // Fixed priority picks bit 7 twice in a row.
        en   = 1'b1;
        req  = 8'b1010_0100;
        tick();
        expect_grant("fp1", 3'd7);
        done = 1'b1;
        tick();
        expect_idle("fp1_rel", 1'b0);
        done = 1'b0;
        tick();
        expect_grant("fp2", 3'd7);
        done = 1'b1;
        tick();
        expect_idle("fp2_rel", 1'b0);

        // Round robin from ptr=0 with all requests high.
        mode = 1'b1;
        req  = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            done = 1'b0;
            tick();
            expect_grant($sformatf("rr%0d", i), 3'(i % 8));
            done = 1'b1;
            tick();
            expect_idle($sformatf("rr%0d_rel", i), 1'b0);
        end
        done = 1'b0;

        // ptr=1 now; grant 5, release -> ptr=6, then wrap to 0.
        req = 8'b0010_0000;
        tick();
        expect_grant("wrap_a5", 3'd5);
        done = 1'b1;
        tick();
        expect_idle("wrap_a5_rel", 1'b0);
        done = 1'b0;
        req  = 8'b0000_0011;
        tick();
        expect_grant("wrap_a0", 3'd0);
        req = 8'd0;
        tick();
        expect_idle("wrap_drop", 1'b0);

        // Timeout with MAX_HOLD=4.
        req = 8'b0000_1000;
        tick();
        expect_grant("tmo_c1", 3'd3);
        for (int i = 2; i <= 4; i++) begin
            tick();
            expect_grant($sformatf("tmo_c%0d", i), 3'd3);
        end
        tick();
        expect_idle("tmo_rel", 1'b1);
        req = 8'b0001_1000;
        tick();
        expect_grant("tmo_ptr4", 3'd4);
        done = 1'b1;
        tick();
        expect_idle("tmo_ptr4_rel", 1'b0);
        done = 1'b0;

        // done coincident with the limit cycle is a normal release.
        mode = 1'b0;
        req  = 8'b0000_1000;
        tick();
        expect_grant("dlim_c1", 3'd3);
        tick();
        tick();
        tick();
        expect_grant("dlim_c4", 3'd3);
        done = 1'b1;
        tick();
        expect_idle("dlim_rel", 1'b0);
        done = 1'b0;

        // Enable drop and request drop; other requests ignored while granted.
        req = 8'b0000_0100;
        tick();
        expect_grant("en_g", 3'd2);
        en = 1'b0;
        tick();
        expect_idle("en_rel", 1'b0);
        req = 8'hFF;
        tick();
        expect_idle("en_off_idle", 1'b0);
        en  = 1'b1;
        req = 8'b0000_0100;
        tick();
        expect_grant("req_g", 3'd2);
        req = 8'b1000_0100;
        tick();
        expect_grant("req_ignore7", 3'd2);
        req = 8'b1000_0000;
        tick();
        expect_idle("req_rel", 1'b0);
        req = 8'd0;
        tick();
        expect_idle("req_none", 1'b0);

        // Asynchronous reset in the middle of a grant.
        req = 8'b0010_0000;
        tick();
        expect_grant("rst_g", 3'd5);
        #2;
        rst_n = 1'b0;
        #1;
        expect_idle("rst_async", 1'b0);
        mode = 1'b1;
        req  = 8'hFF;
        tick();
        expect_idle("rst_hold", 1'b0);
        rst_n = 1'b1;
        tick();
        expect_grant("rst_first", 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
